// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package booth_pkg;

  // Controller states: waiting for a request, or iterating.
  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  // Booth radix-4 digit selected from a 3-bit multiplier window.
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4
  } digit_e;

  // Iterations needed for a WIDTH-bit operand extended to WIDTH+2 bits,
  // two multiplier bits retired per iteration.
  function automatic int iter_count(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_mul_if.sv
// Request/result bundle for the Booth multiplier functional unit.
//
// Handshake: the master raises start for at least one cycle with x, y and
// signed_mode valid. The request is taken at the first rising edge where
// the unit is idle (busy=0); start while busy=1 is dropped, not queued.
// busy is high for the whole computation. done pulses for exactly one
// cycle when z is updated; z then holds until the next done. A new start
// may be presented in the done cycle itself.
interface booth_r4_mul_if #(
  parameter int WIDTH = 16
);
  import booth_pkg::*;

  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic [2*WIDTH-1:0] z;
  logic               busy;
  logic               done;
  state_e             state_dbg;

  modport master (
    output start, signed_mode, x, y,
    input  z, busy, done, state_dbg
  );

  modport slave (
    input  start, signed_mode, x, y,
    output z, busy, done, state_dbg
  );

endinterface

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth encoder: maps a 3-bit multiplier window to the signed
// multiple of the extended multiplicand, widened to WIDTH+3 bits.
module booth_r4_enc
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       win,
  input  logic [WIDTH+1:0] x_ext,
  output logic [WIDTH+2:0] mult
);

  digit_e           digit;
  logic [WIDTH+2:0] x1;
  logic [WIDTH+2:0] x2;

  // 1X is a sign extension; 2X is a left shift that still fits because
  // x_ext already carries two copies of the sign bit.
  assign x1 = {x_ext[WIDTH+1], x_ext};
  assign x2 = {x_ext, 1'b0};

  // Decode the window {Q[1], Q[0], Q[-1]} into a Booth digit.
  always_comb begin
    digit = ZERO;
    case (win)
      3'b000, 3'b111: digit = ZERO;
      3'b001, 3'b010: digit = P1;
      3'b011:         digit = P2;
      3'b100:         digit = M2;
      default:        digit = M1;
    endcase
  end

  // Select the multiple; negation is modulo 2^(WIDTH+3).
  always_comb begin
    mult = '0;
    case (digit)
      ZERO:    mult = '0;
      P1:      mult = x1;
      P2:      mult = x2;
      M1:      mult = -x1;
      M2:      mult = -x2;
      default: mult = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_mul.sv
// Sequential radix-4 Booth multiplier, signed or unsigned at runtime.
// Operands are extended to WIDTH+2 bits so most-negative and all-ones
// corner products come out exact; A is WIDTH+3 bits to hold +/-2X sums.
module booth_r4_mul
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  booth_r4_mul_if.slave  bus
);

  localparam int N  = iter_count(WIDTH);
  localparam int CW = $clog2(N + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH+2:0]   a_q, a_d;
  logic [WIDTH+1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [WIDTH+1:0]   xe_q, xe_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic               done_q, done_d;

  logic [WIDTH+2:0]   mult;
  logic [WIDTH+2:0]   sum;
  logic [2*WIDTH+5:0] shifted;

  booth_r4_enc #(.WIDTH(WIDTH)) u_enc (
    .win   ({q_q[1], q_q[0], qm1_q}),
    .x_ext (xe_q),
    .mult  (mult)
  );

  // {A,Q,Q[-1]} after adding the selected multiple and an arithmetic
  // shift right by two; the two dropped bits are Q[0] and Q[-1].
  assign sum     = a_q + mult;
  assign shifted = {{2{sum[WIDTH+2]}}, sum, q_q[WIDTH+1:1]};

  // Next-state logic: capture in IDLE, one Booth iteration per CALC cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    xe_d    = xe_q;
    z_d     = z_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.signed_mode) begin
            xe_d = {{2{bus.x[WIDTH-1]}}, bus.x};
            q_d  = {{2{bus.y[WIDTH-1]}}, bus.y};
          end else begin
            xe_d = {2'b00, bus.x};
            q_d  = {2'b00, bus.y};
          end
          qm1_d   = 1'b0;
          a_d     = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = shifted[2*WIDTH+5:WIDTH+3];
        q_d   = shifted[WIDTH+2:1];
        qm1_d = shifted[0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          z_d     = shifted[2*WIDTH:1];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers; reset aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      xe_q    <= '0;
      z_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      xe_q    <= xe_d;
      z_q     <= z_d;
      done_q  <= done_d;
    end
  end

  assign bus.z         = z_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q == CALC);
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_booth_r4_mul.sv
// Bench for booth_r4_mul: a 16-bit instance driven from a vector table and
// hand sequences, and an 8-bit instance swept against a reference model.
module tb_booth_r4_mul;
  import booth_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst16 = 1'b1;
  logic rst8  = 1'b1;

  booth_r4_mul_if #(.WIDTH(16)) if16 ();
  booth_r4_mul_if #(.WIDTH(8))  if8 ();

  booth_r4_mul #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst16), .bus(if16));
  booth_r4_mul #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .bus(if8));

  localparam int N16 = 9;
  localparam int N8  = 5;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp16_q[$];
  logic [15:0] exp8_q[$];
  logic [31:0] last16;
  logic [15:0] last8;
  int busy_run16 = 0, busy_run8 = 0;
  int done_n16 = 0, done_n8 = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endfunction

  // ---------------- reference models ----------------
  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic s);
    longint ea, eb, p;
    ea = s ? longint'($signed(a)) : longint'(a);
    eb = s ? longint'($signed(b)) : longint'(b);
    p  = ea * eb;
    return p[31:0];
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int ea, eb, p;
    ea = s ? int'($signed(a)) : int'(a);
    eb = s ? int'($signed(b)) : int'(b);
    p  = ea * eb;
    return p[15:0];
  endfunction

  // ---------------- scoreboards (sample on falling edge) ----------------
  always @(negedge clk) begin
    if (rst16) begin
      busy_run16 = 0;
      last16     = '0;
    end else if (if16.done) begin
      done_n16++;
      chk("busy_len16", 64'(busy_run16), 64'(N16));
      busy_run16 = 0;
      if (exp16_q.size() == 0) chk("unexpected_done16", 1, 0);
      else begin
        last16 = exp16_q.pop_front();
        chk("z16", 64'(if16.z), 64'(last16));
      end
    end else if (if16.busy) begin
      busy_run16++;
      chk("z_hold16", 64'(if16.z), 64'(last16));
    end
  end

  always @(negedge clk) begin
    if (rst8) begin
      busy_run8 = 0;
      last8     = '0;
    end else if (if8.done) begin
      done_n8++;
      chk("busy_len8", 64'(busy_run8), 64'(N8));
      busy_run8 = 0;
      if (exp8_q.size() == 0) chk("unexpected_done8", 1, 0);
      else begin
        last8 = exp8_q.pop_front();
        chk("z8", 64'(if8.z), 64'(last8));
      end
    end else if (if8.busy) begin
      busy_run8++;
    end
  end

  // ---------------- driver tasks (called at a falling edge, unit idle) ----------------
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [31:0] e);
    int cyc;
    bit got;
    if16.x = a; if16.y = b; if16.signed_mode = s; if16.start = 1'b1;
    exp16_q.push_back(e);
    @(negedge clk);
    if16.start = 1'b0;
    cyc = 1;
    chk("busy_after_start16", 64'(if16.busy), 1);
    got = 0;
    while (!got && cyc < 40) begin
      if16.x = 16'($urandom);
      if16.y = 16'($urandom);
      if16.signed_mode = 1'($urandom);
      @(negedge clk);
      cyc++;
      if (if16.done) got = 1;
    end
    chk("latency16", 64'(cyc), 64'(N16 + 1));
    if (!got && exp16_q.size() != 0) void'(exp16_q.pop_back());
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int cyc;
    bit got;
    if8.x = a; if8.y = b; if8.signed_mode = s; if8.start = 1'b1;
    exp8_q.push_back(ref8(a, b, s));
    @(negedge clk);
    if8.start = 1'b0;
    cyc = 1;
    got = 0;
    while (!got && cyc < 30) begin
      if8.x = 8'($urandom);
      if8.y = 8'($urandom);
      @(negedge clk);
      cyc++;
      if (if8.done) got = 1;
    end
    chk("latency8", 64'(cyc), 64'(N8 + 1));
    if (!got && exp8_q.size() != 0) void'(exp8_q.pop_back());
  endtask

  task automatic wait_done16(output bit got);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (if16.done) got = 1;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        s;
    logic [31:0] e;
  } vec_t;

  vec_t tbl[10];

  // ---------------- 16-bit test ----------------
  initial begin
    int d0;
    bit got;
    if16.start = 1'b0; if16.signed_mode = 1'b0; if16.x = '0; if16.y = '0;
    tbl[0] = '{16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB};
    tbl[1] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
    tbl[2] = '{16'h8000, 16'h8000, 1'b0, 32'h40000000};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
    tbl[5] = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001};
    tbl[6] = '{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000};
    tbl[7] = '{16'h1234, 16'h5678, 1'b0, 32'h06260060};
    tbl[8] = '{16'h0000, 16'hBEEF, 1'b1, 32'h00000000};
    tbl[9] = '{16'h8000, 16'h0001, 1'b0, 32'h00008000};

    #1;
    chk("rst_busy16", 64'(if16.busy), 0);
    chk("rst_done16", 64'(if16.done), 0);
    chk("rst_z16", 64'(if16.z), 0);
    chk("rst_state16", 64'(if16.state_dbg), 64'(IDLE));
    @(negedge clk);
    rst16 = 1'b0;
    @(negedge clk);

    // Table vectors issued back-to-back: each start lands in the done cycle.
    for (int i = 0; i < 10; i++) run16(tbl[i].x, tbl[i].y, tbl[i].s, tbl[i].e);

    // Random products against the model.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] a, b;
      logic s;
      a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
      run16(a, b, s, ref16(a, b, s));
    end

    // Start and new operands pulsed mid-computation must be ignored.
    @(negedge clk);
    d0 = done_n16;
    if16.x = 16'h1234; if16.y = 16'h5678; if16.signed_mode = 1'b0; if16.start = 1'b1;
    exp16_q.push_back(32'h06260060);
    @(negedge clk);
    if16.start = 1'b0;
    repeat (3) @(negedge clk);
    if16.x = 16'hFFFF; if16.y = 16'hFFFF; if16.signed_mode = 1'b1; if16.start = 1'b1;
    @(negedge clk);
    if16.start = 1'b0;
    wait_done16(got);
    chk("midcalc_done_seen", 64'(got), 1);
    repeat (15) @(negedge clk);
    chk("midcalc_one_done", 64'(done_n16 - d0), 1);

    // Reset after four iterations aborts with outputs cleared.
    if16.x = 16'hFFFD; if16.y = 16'h0007; if16.signed_mode = 1'b1; if16.start = 1'b1;
    @(negedge clk);
    if16.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_z16", 64'(if16.z), 64'h06260060);
    rst16 = 1'b1;
    #1;
    chk("abort_busy16", 64'(if16.busy), 0);
    chk("abort_done16", 64'(if16.done), 0);
    chk("abort_z16", 64'(if16.z), 0);
    chk("abort_state16", 64'(if16.state_dbg), 64'(IDLE));
    @(negedge clk);
    rst16 = 1'b0;
    d0 = done_n16;
    repeat (15) @(negedge clk);
    chk("no_done_after_abort", 64'(done_n16 - d0), 0);
    run16(16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB);
    run16(16'h8000, 16'h8000, 1'b1, 32'h40000000);
    repeat (3) @(negedge clk);
    chk("queue_empty16", 64'(exp16_q.size()), 0);
  end

  // ---------------- 8-bit sweep, then report ----------------
  initial begin
    logic [7:0] xs[5];
    if8.start = 1'b0; if8.signed_mode = 1'b0; if8.x = '0; if8.y = '0;
    xs[0] = 8'h00; xs[1] = 8'h01; xs[2] = 8'h7F; xs[3] = 8'h80; xs[4] = 8'hFF;
    #1;
    chk("rst_busy8", 64'(if8.busy), 0);
    chk("rst_z8", 64'(if8.z), 0);
    @(negedge clk);
    rst8 = 1'b0;
    @(negedge clk);
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 256; j++)
          run8(xs[i], 8'(j), 1'(m));
    for (int i = 0; i < 800; i++)
      run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'(i % 2));
    repeat (3) @(negedge clk);
    chk("queue_empty8", 64'(exp8_q.size()), 0);

    // The 16-bit sequence is far shorter; give it margin to finish.
    repeat (200) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
